// File: rtl/multiply_arbiter.sv
// multiply_arbiter: shares one multiply unit between N requesters.
// Round-robin arbitration, one transaction in flight, product returned
// only to the requester that issued the argument.
//
// state   | meaning
// IDLE    | arbitrating; winner's argument accepted and captured
// ISSUE   | argument presented to the multiplier until accepted
// WAIT    | waiting for the multiplier product
// DELIVER | product presented to the granted requester until accepted
module multiply_arbiter #(
    parameter int N    = 4,
    parameter int ARGW = 16,
    parameter int ARGD = 2,
    parameter int RESW = 32,
    parameter int IDW  = $clog2(N)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           req_arg_valid,
    input  logic [N*ARGD*ARGW-1:0] req_arg_data,
    output logic [N-1:0]           req_arg_ready,
    output logic [N-1:0]           req_res_valid,
    output logic [RESW-1:0]        req_res_data,
    input  logic [N-1:0]           req_res_ready,
    output logic                   mul_arg_valid,
    output logic [ARGD*ARGW-1:0]   mul_arg_data,
    input  logic                   mul_arg_ready,
    input  logic                   mul_res_valid,
    input  logic [RESW-1:0]        mul_res_data,
    output logic                   mul_res_ready,
    output logic [IDW-1:0]         grant,
    output logic                   busy
);

    localparam int AW = ARGD * ARGW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  lo_win;
    logic [IDW-1:0]  hi_win;
    logic            lo_found;
    logic            hi_found;
    logic            win_found;
    logic [AW-1:0]   win_arg;
    logic [AW-1:0]   arg_q;
    logic [RESW-1:0] res_q;

    // Round-robin pick: lowest valid index at or above ptr, otherwise wrap
    // around to the lowest valid index overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_win   = '0;
        hi_win   = '0;
        win_arg  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_arg_valid[i]) begin
                lo_found = 1'b1;
                lo_win   = IDW'(i);
                if (IDW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_win   = IDW'(i);
                end
            end
        end
        win_found = lo_found;
        win       = hi_found ? hi_win : lo_win;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == win) begin
                win_arg = req_arg_data[i*AW +: AW];
            end
        end
    end

    // Accept is combinational so capture lands on the IDLE->ISSUE edge;
    // gated by reset so no requester sees ready while the block is held.
    assign req_arg_ready = (!reset && state == IDLE && win_found) ? (N'(1) << win) : '0;
    assign ptr_next      = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
    assign mul_arg_data  = arg_q;
    assign req_res_data  = res_q;

    // Transaction sequencer with registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            grant         <= '0;
            arg_q         <= '0;
            res_q         <= '0;
            mul_arg_valid <= 1'b0;
            mul_res_ready <= 1'b0;
            req_res_valid <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        arg_q         <= win_arg;
                        grant         <= win;
                        mul_arg_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_arg_ready) begin
                        mul_arg_valid <= 1'b0;
                        mul_res_ready <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mul_res_valid) begin
                        res_q         <= mul_res_data;
                        mul_res_ready <= 1'b0;
                        req_res_valid <= N'(1) << grant;
                        state         <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (req_res_ready[grant]) begin
                        req_res_valid <= '0;
                        busy          <= 1'b0;
                        ptr           <= ptr_next;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_arbiter.sv
// Bench for multiply_arbiter: random requesters, a behavioural multiplier
// with variable latency, and a scoreboard of expected (requester, product).
module tb_multiply_arbiter;

    localparam int N    = 4;
    localparam int ARGW = 16;
    localparam int ARGD = 2;
    localparam int RESW = 32;
    localparam int IDW  = 2;
    localparam int AW   = ARGD * ARGW;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_arg_valid;
    logic [N*AW-1:0]   req_arg_data;
    logic [N-1:0]      req_arg_ready;
    logic [N-1:0]      req_res_valid;
    logic [RESW-1:0]   req_res_data;
    logic [N-1:0]      req_res_ready;
    logic              mul_arg_valid;
    logic [AW-1:0]     mul_arg_data;
    logic              mul_arg_ready;
    logic              mul_res_valid;
    logic [RESW-1:0]   mul_res_data;
    logic              mul_res_ready;
    logic [IDW-1:0]    grant;
    logic              busy;

    multiply_arbiter #(.N(N), .ARGW(ARGW), .ARGD(ARGD), .RESW(RESW), .IDW(IDW)) dut (
        .clock(clock), .reset(reset),
        .req_arg_valid(req_arg_valid), .req_arg_data(req_arg_data), .req_arg_ready(req_arg_ready),
        .req_res_valid(req_res_valid), .req_res_data(req_res_data), .req_res_ready(req_res_ready),
        .mul_arg_valid(mul_arg_valid), .mul_arg_data(mul_arg_data), .mul_arg_ready(mul_arg_ready),
        .mul_res_valid(mul_res_valid), .mul_res_data(mul_res_data), .mul_res_ready(mul_res_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [IDW-1:0] id; logic [RESW-1:0] prod; } exp_t;
    typedef struct packed { logic [IDW-1:0] id; logic [AW-1:0] arg; } offer_t;

    exp_t            exp_q[$];
    offer_t          offer_q[$];
    int              del_ids[$];
    logic [RESW-1:0] del_data[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              n_acc;
    int              n_del;
    int              m_ptr;
    logic            hold_arg  = 1'b0;
    logic            hold_res  = 1'b0;
    logic            long_lat  = 1'b0;
    logic            full_mode = 1'b0;
    logic            rand_en   = 1'b0;
    logic [AW-1:0]   issued_arg;

    function automatic logic [RESW-1:0] ref_mul(logic [AW-1:0] arg);
        int unsigned a, b;
        a = 32'(arg[AW-1:ARGW]);
        b = 32'(arg[ARGW-1:0]);
        return a * b;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    // requesters: drive offers, check arbitration, push expectations on accept
    initial begin : drv
        logic         acc_hit;
        int           acc_id;
        int           ix;
        logic [AW-1:0] acc_arg;
        logic [N-1:0] exp_rdy;
        offer_t       o;
        req_arg_valid = '0;
        req_arg_data  = '0;
        issued_arg    = '0;
        n_acc         = 0;
        forever begin
            @(negedge clock);
            acc_hit = 1'b0;
            acc_id  = 0;
            if (!reset) begin
                exp_rdy = '0;
                if (n_acc == n_del) begin
                    for (int k = 0; k < N; k++) begin
                        ix = (m_ptr + k) % N;
                        if (exp_rdy == '0 && req_arg_valid[ix]) exp_rdy[ix] = 1'b1;
                    end
                end
                chk("arg_ready", 64'(req_arg_ready), 64'(exp_rdy));
                for (int i = 0; i < N; i++) begin
                    if (!acc_hit && req_arg_ready[i] && req_arg_valid[i]) begin
                        acc_hit = 1'b1;
                        acc_id  = i;
                    end
                end
                if (acc_hit) begin
                    acc_arg    = req_arg_data[acc_id*AW +: AW];
                    exp_q.push_back('{id: IDW'(acc_id), prod: ref_mul(acc_arg)});
                    issued_arg = acc_arg;
                    n_acc++;
                end
            end
            @(posedge clock);
            #1;
            if (reset) begin
                req_arg_valid = '0;
                n_acc         = 0;
            end else begin
                if (acc_hit) req_arg_valid[acc_id] = 1'b0;
                while (offer_q.size() > 0) begin
                    o = offer_q.pop_front();
                    req_arg_valid[o.id] = 1'b1;
                    req_arg_data[int'(o.id)*AW +: AW] = o.arg;
                end
                for (int i = 0; i < N; i++) begin
                    if (!req_arg_valid[i] && (full_mode || (rand_en && $urandom_range(0, 3) == 0))) begin
                        req_arg_valid[i] = 1'b1;
                        req_arg_data[i*AW +: AW] = $urandom;
                    end
                end
            end
        end
    end

    // behavioural multiplier: random accept, 1..3 cycle latency (long on demand)
    initial begin : mul_stub
        logic          afire, rfire, pend;
        logic [AW-1:0] held;
        int            lat;
        mul_arg_ready = 1'b0;
        mul_res_valid = 1'b0;
        mul_res_data  = '0;
        pend = 1'b0;
        held = '0;
        lat  = 0;
        forever begin
            @(negedge clock);
            afire = !reset && mul_arg_valid && mul_arg_ready;
            rfire = !reset && mul_res_valid && mul_res_ready;
            if (afire) begin
                chk("mul_arg_data", 64'(mul_arg_data), 64'(issued_arg));
                held = mul_arg_data;
            end
            @(posedge clock);
            #1;
            if (reset) begin
                mul_res_valid = 1'b0;
                mul_arg_ready = 1'b0;
                pend = 1'b0;
            end else begin
                if (rfire) begin
                    mul_res_valid = 1'b0;
                    mul_res_data  = $urandom;
                end
                if (afire) begin
                    pend = 1'b1;
                    lat  = long_lat ? 40 : $urandom_range(0, 2);
                end
                if (pend && !mul_res_valid) begin
                    if (lat == 0) begin
                        mul_res_valid = 1'b1;
                        mul_res_data  = ref_mul(held);
                        pend = 1'b0;
                    end else begin
                        lat--;
                    end
                end
                mul_arg_ready = hold_arg ? 1'b0 : ($urandom_range(0, 2) != 0);
            end
        end
    end

    // monitor: pop scoreboard on every result handshake and compare
    initial begin : mon
        logic         fire;
        exp_t         e;
        logic [N-1:0] want;
        req_res_ready = '0;
        n_del = 0;
        m_ptr = 0;
        e     = '0;
        forever begin
            @(negedge clock);
            fire = !reset && ((req_res_valid & req_res_ready) != '0);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(req_res_valid), 64'(0));
                    e = '0;
                end else begin
                    e    = exp_q.pop_front();
                    want = N'(1) << e.id;
                    chk("res_valid", 64'(req_res_valid), 64'(want));
                    chk("res_data", 64'(req_res_data), 64'(e.prod));
                    chk("grant", 64'(grant), 64'(e.id));
                end
                del_ids.push_back(int'(e.id));
                del_data.push_back(req_res_data);
            end
            @(posedge clock);
            #1;
            if (reset) begin
                exp_q.delete();
                n_del = 0;
                m_ptr = 0;
                req_res_ready = '0;
            end else begin
                if (fire) begin
                    n_del++;
                    m_ptr = (int'(e.id) + 1) % N;
                end
                for (int i = 0; i < N; i++) req_res_ready[i] = hold_res ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_ctrl", 64'({req_arg_ready, req_res_valid, mul_arg_valid, mul_res_ready, busy, grant}), 64'(0));
        chk("rst_data", 64'({req_res_data, mul_arg_data}), 64'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic offer(int id, logic [AW-1:0] arg);
        offer_q.push_back('{id: IDW'(id), arg: arg});
    endtask

    task automatic drain(string name, int budget);
        int t;
        t = 0;
        while (t < budget && !(exp_q.size() == 0 && offer_q.size() == 0 && req_arg_valid == '0 && !busy)) begin
            @(negedge clock);
            t++;
        end
        if (t >= budget) fail(name);
    endtask

    task automatic clear_log();
        del_ids.delete();
        del_data.delete();
    endtask

    task automatic sc_single();
        clear_log();
        offer(0, 32'h0080_0080);
        drain("single1_drain", 200);
        offer(0, 32'h0100_0100);
        drain("single2_drain", 200);
        chk("single_count", 64'(del_ids.size()), 64'(2));
        if (del_ids.size() == 2) begin
            chk("single_id0", 64'(del_ids[0]), 64'(0));
            chk("single_res0", 64'(del_data[0]), 64'h0000_4000);
            chk("single_id1", 64'(del_ids[1]), 64'(0));
            chk("single_res1", 64'(del_data[1]), 64'h0001_0000);
        end
    endtask

    task automatic sc_contention();
        do_reset();
        clear_log();
        offer(1, 32'h7fff_0000);
        offer(2, 32'h0080_0080);
        drain("cont_drain", 300);
        chk("cont_count", 64'(del_ids.size()), 64'(2));
        if (del_ids.size() == 2) begin
            chk("cont_id0", 64'(del_ids[0]), 64'(1));
            chk("cont_res0", 64'(del_data[0]), 64'h0);
            chk("cont_id1", 64'(del_ids[1]), 64'(2));
            chk("cont_res1", 64'(del_data[1]), 64'h0000_4000);
        end
    endtask

    initial begin : main
        int            t;
        logic [AW-1:0] d0;
        logic [RESW-1:0] r0;

        do_reset();
        sc_single();
        sc_contention();

        // fairness with all requesters held valid
        do_reset();
        clear_log();
        full_mode = 1'b1;
        t = 0;
        while (t < 600 && del_ids.size() < 8) begin
            @(negedge clock);
            t++;
        end
        if (t >= 600) fail("fair_wait");
        full_mode = 1'b0;
        drain("fair_drain", 600);
        if (del_ids.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("fair_order", 64'(del_ids[k]), 64'(k % N));
        end else begin
            chk("fair_count", 64'(del_ids.size()), 64'(8));
        end

        // multiplier argument backpressure
        hold_arg = 1'b1;
        offer(0, $urandom);
        t = 0;
        while (t < 50 && !mul_arg_valid) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) fail("issue_wait");
        d0 = mul_arg_data;
        repeat (5) begin
            @(negedge clock);
            chk("issue_hold", 64'({mul_arg_valid, mul_res_ready, busy}), 64'(3'b101));
            chk("issue_data", 64'(mul_arg_data), 64'(d0));
        end
        hold_arg = 1'b0;
        drain("issue_drain", 200);

        // result backpressure, with another requester waiting
        hold_res = 1'b1;
        offer(1, $urandom);
        t = 0;
        while (t < 100 && req_res_valid == '0) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) fail("deliver_wait");
        r0 = req_res_data;
        offer(2, $urandom);
        repeat (10) begin
            @(negedge clock);
            chk("deliver_valid", 64'(req_res_valid), 64'(4'b0010));
            chk("deliver_data", 64'(req_res_data), 64'(r0));
            chk("deliver_no_accept", 64'(req_arg_ready), 64'(0));
        end
        hold_res = 1'b0;
        drain("deliver_drain", 300);

        // reset while waiting on the multiplier
        long_lat = 1'b1;
        offer(2, $urandom);
        t = 0;
        while (t < 100 && !mul_res_ready) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) fail("wait_state_wait");
        do_reset();
        long_lat = 1'b0;
        clear_log();
        offer(3, 32'h0100_0100);
        drain("post_rst_drain", 200);
        chk("post_rst_count", 64'(del_ids.size()), 64'(1));
        if (del_ids.size() == 1) begin
            chk("post_rst_id", 64'(del_ids[0]), 64'(3));
            chk("post_rst_res", 64'(del_data[0]), 64'h0001_0000);
        end

        // repeat directed scenarios after a fresh reset
        do_reset();
        sc_single();
        sc_contention();

        // randomized traffic
        clear_log();
        rand_en = 1'b1;
        repeat (3000) @(negedge clock);
        rand_en = 1'b0;
        drain("random_drain", 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/multiply_arbiter.md
# multiply_arbiter

Shares one `multiply` unit between N independent requesters over valid/ready streams. Requesters are arbitrated round-robin, and the winner's argument pair is captured and issued to the multiplier. The product is returned only to the requester that issued it. The block sits between the neuron/layer control logic and the single multiply datapath, with exactly one transaction in flight at a time.

## Interface
- `N`, 4: number of requesters (2..16).
- `ARGW`, 16: width of each operand.
- `ARGD`, 2: operands per argument word; argument width is ARGD*ARGW.
- `RESW`, 32: product width.
- `IDW`, $clog2(N): grant index width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_arg_valid`  in  N  per-requester argument valid.
- `req_arg_data`  in  N*ARGD*ARGW  packed arguments; requester i occupies slice i.
- `req_arg_ready`  out  N  one-hot argument accept.
- `req_res_valid`  out  N  one-hot result valid.
- `req_res_data`  out  RESW  result, shared by all requesters and qualified by `req_res_valid`.
- `req_res_ready`  in  N  per-requester result accept.
- `mul_arg_valid`  out  1  argument valid to the multiplier.
- `mul_arg_data`  out  ARGD*ARGW  argument to the multiplier as {a, b}, with a in the upper ARGW bits.
- `mul_arg_ready`  in  1  multiplier argument accept.
- `mul_res_valid`  in  1  multiplier result valid.
- `mul_res_data`  in  RESW  multiplier result.
- `mul_res_ready`  out  1  result accept to the multiplier.
- `grant`  out  IDW  index of the current or last granted requester (debug).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - The combinational round-robin arbiter scans `req_arg_valid` starting at `ptr`.
  - If any requester is valid, the winner w gets `req_arg_ready[w]`=1 this cycle.
  - Its argument is captured into `arg_q`, `grant` <= w, and the FSM moves to ISSUE.
  - If no requester is valid, the FSM stays in IDLE.
- ISSUE:
  - `mul_arg_valid`=1 and `mul_arg_data`=`arg_q`.
  - When `mul_arg_ready` is high, the FSM moves to WAIT.
  - `mul_arg_valid` stays high until accepted, and `arg_q` is stable while it is high.
- WAIT:
  - `mul_res_ready`=1.
  - When `mul_res_valid` is high, the product is captured into `res_q` and the FSM moves to DELIVER.
- DELIVER:
  - `req_res_valid[grant]`=1 and `req_res_data`=`res_q`.
  - When `req_res_ready[grant]` is high, `ptr` <= grant+1 (mod N) and the FSM moves to IDLE.
- Arbitration priority: `ptr`, `ptr`+1, … wrapping mod N. The last served requester therefore has lowest priority in the next arbitration.
- The arbiter does no arithmetic. `req_res_data` is exactly the RESW-bit `mul_res_data` returned for the issued argument, unmodified.
- Only `req_arg_ready[grant]` can be high, and only in IDLE. Every other requester sees ready=0, so no argument is dropped.
- `mul_res_ready` is 0 outside WAIT, so a stray multiplier result is never consumed early.
- `req_res_ready` of non-granted requesters is ignored.

## Timing
- Reset (async assert, synchronous release):
  - State -> IDLE, `ptr`=0, `grant`=0, `arg_q`=0, `res_q`=0.
  - Outputs: all `req_arg_ready`, `req_res_valid`, `mul_arg_valid`, `mul_res_ready`, and `busy` are 0; `req_res_data`=0.
- Reset mid-transaction aborts it with no result delivered. The multiplier shares the same `reset`, so no stale product survives.
- Minimum transaction length: 1 cycle IDLE, 1 ISSUE, multiplier latency L cycles in WAIT, 1 DELIVER.
  - With zero-stall handshakes and an L=1 multiplier, a transaction takes 4 cycles from accept to delivery-accept.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Argument accept and capture happen on the same edge as the IDLE->ISSUE transition.
- Backpressure:
  - ISSUE and DELIVER hold their outputs indefinitely, with stable data.
  - No new arbitration occurs while `busy`=1.
- With all N requesters continuously valid, grants follow w, w+1, … mod N. No requester waits more than N-1 transactions.

## Test plan
- Single requester: requester 0 sends 0x0080_0080 -> `mul_arg_data`=0x0080_0080, `req_res_valid`=4'b0001, `req_res_data`=0x0000_4000; requester 0 then sends 0x0100_0100 -> result 0x0001_0000.
- Contention: requesters 1 and 2 are valid in the same cycle after reset, with 0x7fff_0000 and 0x0080_0080 -> requester 1 receives 0x0 first, then requester 2 receives 0x4000; `grant` goes 1 then 2.
- Fairness: all four requesters are held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each requester gets exactly 2.
- Backpressure:
  - `mul_arg_ready` held low for 5 cycles -> `mul_arg_valid` and data are stable and the FSM stays in ISSUE.
  - `req_res_ready` held low for 10 cycles -> `req_res_valid` and `req_res_data` are stable and no other requester's `req_arg_ready` rises.
- Reset mid-WAIT -> all outputs return to 0 immediately and `ptr`=0. A subsequent request from requester 3 with 0x0100_0100 completes with 0x10000.
- Reset, then repeat the single-requester and contention scenarios -> identical results.
